dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port DataMemory between two requesters: port A (CPU load/store stage, default priority) and port B (DMA/debug loader).
- Sits directly in front of DataMemory and drives its Addr/Data_in/We while capturing its Data_out.
- Each granted access occupies one memory cycle and is completed with a one-cycle Ack pulse.
- A wait counter bounds B starvation under continuous A traffic.

Parameters:
- ADDR_W, 32, address width passed to DataMemory Addr.
- DATA_W, 32, data width.
- MAX_WAIT, 4, B-waiting cycles after which B wins a tie (legal range 1..15).

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst_n  input  1  asynchronous, active-low reset.
- A_Req  input  1  port A request; held with A_We/A_Addr/A_Wdata stable until A_Ack.
- A_We  input  1  port A write (1) / read (0).
- A_Addr  input  ADDR_W  port A address.
- A_Wdata  input  DATA_W  port A write data.
- A_Ack  output  1  port A completion pulse.
- A_Rdata  output  DATA_W  port A read data, valid while A_Ack=1.
- B_Req, B_We, B_Addr, B_Wdata, B_Ack, B_Rdata: same as port A, for port B.
- Mem_Addr  output  ADDR_W  to DataMemory Addr.
- Mem_Data_in  output  DATA_W  to DataMemory Data_in.
- Mem_We  output  1  to DataMemory We.
- Mem_Data_out  input  DATA_W  from DataMemory Data_out (combinational read).
- Busy  output  1  high in SERVE.
- Owner  output  1  0 = A, 1 = B; holds the last grant.

Behaviour:
- Reset values: state IDLE; A_Ack = B_Ack = 0; A_Rdata = B_Rdata = 0; Mem_Addr = 0; Mem_Data_in = 0; Mem_We = 0; Busy = 0; Owner = 0; wait counter = 0.
- FSM has two states, IDLE and SERVE.
- IDLE:
  - Evaluate eligible requests. A port is eligible when its Req=1 and its Ack is not high in this cycle.
  - If any port is eligible: pick a winner, latch its We/Addr/Wdata into Mem_* registers, set Owner, and go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - Exactly one cycle. Mem_We = latched We. DataMemory writes on the rising edge that ends SERVE.
  - On that same edge, latch Mem_Data_out into the owner's Rdata (reads only; writes leave Rdata unchanged) and set the owner's Ack=1. Return to IDLE.
- Ack: high for exactly one cycle, the cycle after SERVE. The other port's Ack stays 0.
- Latency: Req first seen high at edge k -> SERVE in cycle k+1 -> Ack and Rdata valid in cycle k+2.
- Throughput: a back-to-back access is possible from the Ack cycle, but only for the other port. A held Req on the just-acked port is masked for that cycle, so it restarts one cycle later.
- Mem_We is 0 in every cycle except a write SERVE. Mem_Addr and Mem_Data_in hold their last value in IDLE.
- Arbitration with both ports eligible: A wins, unless wait counter >= MAX_WAIT, in which case B wins.
- Arbitration with only one port eligible: that port wins.
- Wait counter:
  - Increments (saturating at 15) each cycle that B_Req=1 and B is not the owner of the current or next SERVE.
  - Clears to 0 on the IDLE->SERVE edge that grants B.
  - Holds when B_Req=0.
- Req dropped before Ack while still in IDLE: the request is simply not seen. Req dropped during SERVE: the access still completes and Ack still pulses (protocol violation; not checked).
- Reset mid-operation: Rst_n low asynchronously forces IDLE and drops Mem_We and both Acks immediately. A write in SERVE whose ending edge has not occurred is aborted (no memory write). Counter and Rdata clear.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding: IDLE = 1'b0, SERVE = 1'b1;
  - owner encoding: OWN_A = 1'b0, OWN_B = 1'b1;
  - counter width WAIT_W = 4.
- One sub-module, dmem_arb_wait_ctr: saturating counter with inc/clr inputs and a ge_max output compared against MAX_WAIT.
- The arbiter top contains the FSM, grant mux and Rdata/Ack registers.

Test Plan:
- A write then read, B idle: A_We=1, A_Addr=0, A_Wdata=34000 -> Mem_We=1 for exactly one cycle, A_Ack at k+2. Then A read of Addr 0 -> A_Rdata=34000 with A_Ack.
- Simultaneous requests, counter 0: A reads Addr 1, B writes 34001 to Addr 2 -> A served first. B_Ack arrives 2 cycles after A_Ack. Owner sequence is 0 then 1.
- Starvation bound, MAX_WAIT=4: A_Req held high continuously, B_Req held high -> B granted after at most 4 B-waiting cycles. Counter clears to 0 on the B grant; A resumes afterwards.
- Held Req masking: A_Req stays high through A_Ack, B idle -> next A SERVE starts one cycle after the Ack cycle (3-cycle spacing between A_Acks). No Ack is ever high for 2 consecutive cycles.
- Reset during a write SERVE: B writes 55 to Addr 3, Rst_n pulled low mid-SERVE before the edge -> Mem_We=0 at once, no Ack, all outputs at reset values. A later read of Addr 3 returns its old value.
- Read-only port B burst: B reads Addr 0..4 back-to-back with A idle -> five B_Acks, Rdata matches memory contents, Mem_We stays 0 throughout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and widths for the DataMemory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StServe = 1'b1
  } arb_state_e;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating wait counter for port B; flags when the wait has reached MAX_WAIT.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic ge_max_o
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] CntSat  = {WAIT_W{1'b1}};

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntSat)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ge_max_o = (cnt_q >= MaxWait);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: A has priority,
// B is protected from starvation by a bounded wait counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              A_Req,
  input  logic              A_We,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_Wdata,
  output logic              A_Ack,
  output logic [DATA_W-1:0] A_Rdata,
  input  logic              B_Req,
  input  logic              B_We,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_Wdata,
  output logic              B_Ack,
  output logic [DATA_W-1:0] B_Rdata,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data_in,
  output logic              Mem_We,
  input  logic [DATA_W-1:0] Mem_Data_out,
  output logic              Busy,
  output logic              Owner
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic a_elig, b_elig;
  logic grant_b;
  logic wait_inc, wait_ge_max;

  // A port that is being acked this cycle is masked so a held Req cannot
  // re-grant immediately; this is what gives the other port its window.
  assign a_elig = A_Req && !a_ack_q;
  assign b_elig = B_Req && !b_ack_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    grant_b     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (a_elig || b_elig) begin
          grant_b = b_elig && (!a_elig || wait_ge_max);
          state_d = StServe;
          if (grant_b) begin
            owner_d     = OwnB;
            mem_addr_d  = B_Addr;
            mem_wdata_d = B_Wdata;
            mem_we_d    = B_We;
          end else begin
            owner_d     = OwnA;
            mem_addr_d  = A_Addr;
            mem_wdata_d = A_Wdata;
            mem_we_d    = A_We;
          end
        end
      end
      StServe: begin
        state_d = StIdle;
        if (owner_q == OwnB) begin
          b_ack_d = 1'b1;
          if (!mem_we_q) begin
            b_rdata_d = Mem_Data_out;
          end
        end else begin
          a_ack_d = 1'b1;
          if (!mem_we_q) begin
            a_rdata_d = Mem_Data_out;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnA;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  // B waits whenever it asks but is neither being served nor about to be.
  assign wait_inc = B_Req && !((state_q == StServe) && (owner_q == OwnB)) && !grant_b;

  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk_i    (Clk),
    .rst_ni   (Rst_n),
    .inc_i    (wait_inc),
    .clr_i    (grant_b),
    .ge_max_o (wait_ge_max)
  );

  // Gated by state so an asynchronous reset drops the write strobe at once.
  assign Mem_We      = (state_q == StServe) && mem_we_q;
  assign Mem_Addr    = mem_addr_q;
  assign Mem_Data_in = mem_wdata_q;
  assign Busy        = (state_q == StServe);
  assign Owner       = owner_q;
  assign A_Ack       = a_ack_q;
  assign B_Ack       = b_ack_q;
  assign A_Rdata     = a_rdata_q;
  assign B_Rdata     = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a small behavioural DataMemory.
module tb_dmem_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        A_Req, A_We, B_Req, B_We;
  logic [31:0] A_Addr, A_Wdata, B_Addr, B_Wdata;
  logic        A_Ack, B_Ack, Mem_We, Busy, Owner;
  logic [31:0] A_Rdata, B_Rdata, Mem_Addr, Mem_Data_in, Mem_Data_out;

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .A_Req        (A_Req),
    .A_We         (A_We),
    .A_Addr       (A_Addr),
    .A_Wdata      (A_Wdata),
    .A_Ack        (A_Ack),
    .A_Rdata      (A_Rdata),
    .B_Req        (B_Req),
    .B_We         (B_We),
    .B_Addr       (B_Addr),
    .B_Wdata      (B_Wdata),
    .B_Ack        (B_Ack),
    .B_Rdata      (B_Rdata),
    .Mem_Addr     (Mem_Addr),
    .Mem_Data_in  (Mem_Data_in),
    .Mem_We       (Mem_We),
    .Mem_Data_out (Mem_Data_out),
    .Busy         (Busy),
    .Owner        (Owner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory preloaded with 0x100+i so untouched words have known contents.
  logic [31:0] mem [16];
  logic        mem_loaded;
  assign Mem_Data_out = mem[Mem_Addr[3:0]];
  always @(posedge Clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
    end else if (Mem_We) begin
      mem[Mem_Addr[3:0]] <= Mem_Data_in;
    end
  end

  typedef struct {
    logic        ar, aw;
    logic [31:0] aa, ad;
    logic        br, bw;
    logic [31:0] ba, bd;
    logic [4:0]  e;        // {busy, owner, mem_we, a_ack, b_ack}
    logic        cm;
    logic [31:0] maddr, mdin;
    logic        cra;
    logic [31:0] ard;
    logic        crb;
    logic [31:0] brd;
  } vec_t;

  vec_t vecs [80];
  int   nv;
  int   checks;
  int   errors;

  task automatic add(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                     input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                     input logic [4:0] e);
    vecs[nv].ar = ar; vecs[nv].aw = aw; vecs[nv].aa = aa; vecs[nv].ad = ad;
    vecs[nv].br = br; vecs[nv].bw = bw; vecs[nv].ba = ba; vecs[nv].bd = bd;
    vecs[nv].e = e;
    vecs[nv].cm = 1'b0; vecs[nv].maddr = '0; vecs[nv].mdin = '0;
    vecs[nv].cra = 1'b0; vecs[nv].ard = '0;
    vecs[nv].crb = 1'b0; vecs[nv].brd = '0;
    nv++;
  endtask

  task automatic exp_mem(input logic [31:0] addr, input logic [31:0] din);
    vecs[nv-1].cm = 1'b1; vecs[nv-1].maddr = addr; vecs[nv-1].mdin = din;
  endtask

  task automatic exp_ard(input logic [31:0] v);
    vecs[nv-1].cra = 1'b1; vecs[nv-1].ard = v;
  endtask

  task automatic exp_brd(input logic [31:0] v);
    vecs[nv-1].crb = 1'b1; vecs[nv-1].brd = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " A_Ack"}, {31'b0, A_Ack}, 32'd0);
    chk({tag, " B_Ack"}, {31'b0, B_Ack}, 32'd0);
    chk({tag, " Mem_We"}, {31'b0, Mem_We}, 32'd0);
    chk({tag, " Busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, " Owner"}, {31'b0, Owner}, 32'd0);
    chk({tag, " Mem_Addr"}, Mem_Addr, 32'd0);
    chk({tag, " Mem_Data_in"}, Mem_Data_in, 32'd0);
    chk({tag, " A_Rdata"}, A_Rdata, 32'd0);
    chk({tag, " B_Rdata"}, B_Rdata, 32'd0);
  endtask

  logic [31:0] burst_rd [5];

  initial begin
    checks = 0; errors = 0; nv = 0;
    mem_loaded = 1'b0;
    Rst_n = 1'b0;
    A_Req = 0; A_We = 0; A_Addr = '0; A_Wdata = '0;
    B_Req = 0; B_We = 0; B_Addr = '0; B_Wdata = '0;

    // A write then read back, B idle
    add(1, 1, 0, 34000, 0, 0, 0, 0, 5'b10100); exp_mem(0, 34000);
    add(1, 1, 0, 34000, 0, 0, 0, 0, 5'b00010);
    add(0, 0, 0, 0,     0, 0, 0, 0, 5'b00000);
    add(1, 0, 0, 0,     0, 0, 0, 0, 5'b10000); exp_mem(0, 0);
    add(1, 0, 0, 0,     0, 0, 0, 0, 5'b00010); exp_ard(34000);
    add(0, 0, 0, 0,     0, 0, 0, 0, 5'b00000); exp_ard(34000);
    // Simultaneous requests with counter at 0: A first, B two cycles later
    add(1, 0, 1, 0, 1, 1, 2, 34001, 5'b10000); exp_mem(1, 0);
    add(1, 0, 1, 0, 1, 1, 2, 34001, 5'b00010); exp_ard(32'h101);
    add(0, 0, 0, 0, 1, 1, 2, 34001, 5'b11100); exp_mem(2, 34001);
    add(0, 0, 0, 0, 1, 1, 2, 34001, 5'b01001);
    add(0, 0, 0, 0, 0, 0, 0, 0,     5'b01000);
    // Held A request: masked in the Ack cycle, 3-cycle Ack spacing
    add(1, 0, 2, 0, 0, 0, 0, 0, 5'b10000);
    add(1, 0, 2, 0, 0, 0, 0, 0, 5'b00010); exp_ard(34001);
    add(1, 0, 2, 0, 0, 0, 0, 0, 5'b00000);
    add(1, 0, 2, 0, 0, 0, 0, 0, 5'b10000);
    add(1, 0, 2, 0, 0, 0, 0, 0, 5'b00010);
    add(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    // Starvation bound: B waits during four A SERVE cycles, then beats A in a tie
    for (int k = 0; k < 4; k++) begin
      add(1, 0, 0, 0, 0, 0, 4, 0, 5'b10000);
      add(1, 0, 0, 0, 1, 0, 4, 0, 5'b00010); exp_ard(34000);
      add(1, 0, 0, 0, 0, 0, 4, 0, 5'b00000);
    end
    add(1, 0, 0, 0, 1, 0, 4, 0, 5'b11000); exp_mem(4, 0);
    add(1, 0, 0, 0, 1, 0, 4, 0, 5'b01001); exp_brd(32'h104);
    add(1, 0, 0, 0, 0, 0, 0, 0, 5'b10000); exp_mem(0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 5'b00010); exp_ard(34000);
    add(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    // Read-only B burst over addresses 0..4
    burst_rd[0] = 34000; burst_rd[1] = 32'h101; burst_rd[2] = 34001;
    burst_rd[3] = 32'h103; burst_rd[4] = 32'h104;
    for (int j = 0; j < 5; j++) begin
      add(0, 0, 0, 0, 1, 0, j, 0, 5'b11000); exp_mem(j, 0);
      add(0, 0, 0, 0, 1, 0, j, 0, 5'b01001); exp_brd(burst_rd[j]);
      add(0, 0, 0, 0, (j < 4), 0, j + 1, 0, 5'b01000);
    end

    repeat (3) @(posedge Clk);
    mem_loaded = 1'b1;
    #1;
    chk_reset_outputs("reset");
    Rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      A_Req = vecs[i].ar; A_We = vecs[i].aw; A_Addr = vecs[i].aa; A_Wdata = vecs[i].ad;
      B_Req = vecs[i].br; B_We = vecs[i].bw; B_Addr = vecs[i].ba; B_Wdata = vecs[i].bd;
      tick();
      chk($sformatf("v%0d Busy", i),   {31'b0, Busy},   {31'b0, vecs[i].e[4]});
      chk($sformatf("v%0d Owner", i),  {31'b0, Owner},  {31'b0, vecs[i].e[3]});
      chk($sformatf("v%0d Mem_We", i), {31'b0, Mem_We}, {31'b0, vecs[i].e[2]});
      chk($sformatf("v%0d A_Ack", i),  {31'b0, A_Ack},  {31'b0, vecs[i].e[1]});
      chk($sformatf("v%0d B_Ack", i),  {31'b0, B_Ack},  {31'b0, vecs[i].e[0]});
      if (vecs[i].cm) begin
        chk($sformatf("v%0d Mem_Addr", i),    Mem_Addr,    vecs[i].maddr);
        chk($sformatf("v%0d Mem_Data_in", i), Mem_Data_in, vecs[i].mdin);
      end
      if (vecs[i].cra) chk($sformatf("v%0d A_Rdata", i), A_Rdata, vecs[i].ard);
      if (vecs[i].crb) chk($sformatf("v%0d B_Rdata", i), B_Rdata, vecs[i].brd);
    end

    // Reset in the middle of a B write SERVE aborts the write
    A_Req = 0; B_Req = 1; B_We = 1; B_Addr = 3; B_Wdata = 55;
    tick();
    chk("rst_pre Busy", {31'b0, Busy}, 32'd1);
    chk("rst_pre Mem_We", {31'b0, Mem_We}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    B_Req = 0; B_We = 0;
    tick();
    chk_reset_outputs("rst_hold");
    Rst_n = 1'b1;
    tick();
    A_Req = 1; A_We = 0; A_Addr = 3;
    tick();
    chk("rst_rd Busy", {31'b0, Busy}, 32'd1);
    tick();
    chk("rst_rd A_Ack", {31'b0, A_Ack}, 32'd1);
    chk("rst_rd A_Rdata", A_Rdata, 32'h103);
    A_Req = 0;
    tick();
    chk("rst_rd A_Ack drop", {31'b0, A_Ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
